// File: rtl/gray_pkg.sv
// Shared helpers for the Gray-code counter family: width-generic conversions
// operate on MAX_WIDTH-bit vectors and are truncated by the caller.
package gray_pkg;

    localparam int MAX_WIDTH = 32;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray encoder of arbitrary width.
module gray_enc
    import gray_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = WIDTH'(bin2gray(MAX_WIDTH'(bin)));

endmodule

// File: rtl/gray_counter_n.sv
// Up/down Gray-code counter with enable, synchronous load, wrap or saturate
// at the ends, a registered wrap pulse and a combinational terminal flag.
module gray_counter_n
    import gray_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin,
    output logic             wrap,
    output logic             term
);

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] bin_step;
    logic [WIDTH-1:0] gray_step;
    logic [WIDTH-1:0] gray_load;
    logic             wrap_step;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (bin_q == {WIDTH{1'b1}});
    assign at_zero = (bin_q == '0);

    // Candidate next value for an enabled step; saturation simply keeps bin_q.
    always_comb begin
        bin_step  = bin_q;
        wrap_step = 1'b0;
        if (up) begin
            if (!at_max) begin
                bin_step = bin_q + WIDTH'(1);
            end else if (!SATURATE) begin
                bin_step  = '0;
                wrap_step = 1'b1;
            end
        end else begin
            if (!at_zero) begin
                bin_step = bin_q - WIDTH'(1);
            end else if (!SATURATE) begin
                bin_step  = '1;
                wrap_step = 1'b1;
            end
        end
        // A one-bit wrapping counter wraps on every step, in either direction.
        if (WIDTH == 1 && !SATURATE) begin
            wrap_step = 1'b1;
        end
    end

    gray_enc #(.WIDTH(WIDTH)) u_enc_step (
        .bin  (bin_step),
        .gray (gray_step)
    );

    gray_enc #(.WIDTH(WIDTH)) u_enc_load (
        .bin  (load_val),
        .gray (gray_load)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else if (load) begin
            bin_q  <= load_val;
            gray_q <= gray_load;
            wrap_q <= 1'b0;
        end else if (en) begin
            bin_q  <= bin_step;
            gray_q <= gray_step;
            wrap_q <= wrap_step;
        end else begin
            wrap_q <= 1'b0;
        end
    end

    assign gray = gray_q;
    assign bin  = bin_q;
    assign wrap = wrap_q;
    assign term = up ? at_max : at_zero;

endmodule
